// File: rtl/link_tx.sv
`default_nettype none
// ============================================================================
// Module   : link_tx
// Purpose  : Credit-based link transmitter. Flits from a local producer are
//            staged in a small FIFO and forwarded, one per cycle, to a
//            downstream router. A flit is sent only while credits remain.
//            Each credit_in pulse returns one credit.
// Ports    : clk            - single clock, rising edge
//            rst            - synchronous reset, active low (0 = reset)
//            flit_in        - producer flit
//            flit_valid_in  - flit_in valid
//            flit_ready_out - staging FIFO can accept a flit
//            credit_in      - one-cycle pulse, returns one downstream credit
//            channel_out    - registered flit toward downstream (0 when idle)
//            diff_pair_po   - registered flit-valid, positive leg
//            diff_pair_no   - registered flit-valid, negative leg (~po)
//            credit_count   - credits currently available
//            credit_err     - sticky credit-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module link_tx #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int BUFFER_DEPTH  = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_WIDTH-1:0]           flit_in,
  input  logic                               flit_valid_in,
  output logic                               flit_ready_out,
  input  logic                               credit_in,
  output logic [CHANNEL_WIDTH-1:0]           channel_out,
  output logic                               diff_pair_po,
  output logic                               diff_pair_no,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]  credit_count,
  output logic                               credit_err
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_CRED_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [c_ADDR_W:0]   c_FIFO_FULL   = (c_ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_CRED_W-1:0] c_CREDIT_MAX  = c_CRED_W'(BUFFER_DEPTH);

  // Storage and state
  logic [CHANNEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [c_ADDR_W:0]        count_q, count_d;
  logic [c_CRED_W-1:0]      credit_q, credit_d;
  logic                     err_q, err_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                     po_q, po_d;
  logic                     no_q, no_d;

  logic w_push;
  logic w_send;

  // Ready is forced low during reset so nothing is accepted while clearing.
  assign flit_ready_out = rst && (count_q < c_FIFO_FULL);
  assign w_push         = flit_valid_in && flit_ready_out;
  // Send decision uses only registered state, so a flit pushed at edge k
  // is seen as the FIFO head and sent at edge k+1 at the earliest.
  assign w_send         = (count_q != '0) && (credit_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    err_d    = err_q;
    chan_d   = '0;
    po_d     = 1'b0;
    no_d     = 1'b1;

    // Pointers are log2(FIFO_DEPTH) bits wide, so they wrap naturally.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_send) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      chan_d   = mem_q[rd_ptr_q];
      po_d     = 1'b1;
      no_d     = 1'b0;
    end

    case ({w_push, w_send})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A returned credit and a consumed credit at the same edge cancel.
    if (credit_in && !w_send) begin
      if (credit_q == c_CREDIT_MAX) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end else if (w_send && !credit_in) begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= c_CREDIT_MAX;
      err_q    <= 1'b0;
      chan_q   <= '0;
      po_q     <= 1'b0;
      no_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      chan_q   <= chan_d;
      po_q     <= po_d;
      no_q     <= no_d;
    end
  end

  // Data storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= flit_in;
    end
  end

  assign channel_out  = chan_q;
  assign diff_pair_po = po_q;
  assign diff_pair_no = no_q;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_tx
// Purpose  : Directed self-checking bench for link_tx with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_tx;

  logic        clk;
  logic        rst;
  logic [31:0] flit_in;
  logic        flit_valid_in;
  logic        flit_ready_out;
  logic        credit_in;
  logic [31:0] channel_out;
  logic        diff_pair_po;
  logic        diff_pair_no;
  logic [2:0]  credit_count;
  logic        credit_err;

  int checks;
  int errors;

  link_tx #(
    .CHANNEL_WIDTH(32),
    .BUFFER_DEPTH (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_in       (flit_in),
    .flit_valid_in (flit_valid_in),
    .flit_ready_out(flit_ready_out),
    .credit_in     (credit_in),
    .channel_out   (channel_out),
    .diff_pair_po  (diff_pair_po),
    .diff_pair_no  (diff_pair_no),
    .credit_count  (credit_count),
    .credit_err    (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flit_valid_in = 1'b0;
    credit_in = 1'b0;
    tick();
    chk_eq("rst_ready", {63'd0, flit_ready_out}, 64'd0);
    chk_eq("rst_credit", {61'd0, credit_count}, 64'd4);
    chk_eq("rst_po_no", {62'd0, diff_pair_po, diff_pair_no}, 64'b01);
    rst = 1'b1;
  endtask

  // Idle-output expectation: no flit on the channel.
  task automatic chk_idle(input string tag);
    chk_eq({tag, "_po_no"}, {62'd0, diff_pair_po, diff_pair_no}, 64'b01);
    chk_eq({tag, "_chan"}, {32'd0, channel_out}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flit_in = '0;
    flit_valid_in = 1'b0;
    credit_in = 1'b0;

    // Reset then idle 5 cycles
    do_reset();
    repeat (5) tick();
    chk_eq("idle_credit", {61'd0, credit_count}, 64'd4);
    chk_eq("idle_ready", {63'd0, flit_ready_out}, 64'd1);
    chk_eq("idle_err", {63'd0, credit_err}, 64'd0);
    chk_idle("idle");

    // Single flit latency
    flit_in = 32'hA5A5_0001;
    flit_valid_in = 1'b1;
    tick();                              // edge k: push
    flit_valid_in = 1'b0;
    chk_idle("single_k");
    tick();                              // edge k+1: send
    chk_eq("single_chan", {32'd0, channel_out}, 64'hA5A5_0001);
    chk_eq("single_po_no", {62'd0, diff_pair_po, diff_pair_no}, 64'b10);
    chk_eq("single_credit", {61'd0, credit_count}, 64'd3);
    tick();                              // edge k+2: idle again
    chk_idle("single_k2");
    chk_eq("single_credit2", {61'd0, credit_count}, 64'd3);

    // Credit overflow from reset
    do_reset();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk_eq("ovf_err", {63'd0, credit_err}, 64'd1);
    chk_eq("ovf_credit", {61'd0, credit_count}, 64'd4);
    repeat (3) tick();
    chk_eq("ovf_sticky", {63'd0, credit_err}, 64'd1);
    do_reset();
    chk_eq("ovf_cleared", {63'd0, credit_err}, 64'd0);

    // Six flits back-to-back with only four credits
    for (int i = 1; i <= 6; i++) begin
      flit_in = 32'(i);
      flit_valid_in = 1'b1;
      tick();
      chk_eq("burst_ready", {63'd0, flit_ready_out}, 64'd1);
      if (i == 1) begin
        chk_idle("burst_first");
      end else if (i <= 5) begin
        chk_eq($sformatf("burst_send%0d", i - 1), {32'd0, channel_out}, 64'(i - 1));
        chk_eq("burst_po", {63'd0, diff_pair_po}, 64'd1);
        chk_eq("burst_credit", {61'd0, credit_count}, 64'(5 - i));
      end else begin
        chk_idle("burst_stall");
      end
    end
    flit_valid_in = 1'b0;
    repeat (2) tick();
    chk_idle("held");
    chk_eq("held_credit", {61'd0, credit_count}, 64'd0);
    credit_in = 1'b1;
    tick();                              // credit returns, not yet usable
    credit_in = 1'b0;
    chk_idle("cred_ret");
    chk_eq("cred_ret_cnt", {61'd0, credit_count}, 64'd1);
    tick();
    chk_eq("resume_chan", {32'd0, channel_out}, 64'd5);
    chk_eq("resume_po", {63'd0, diff_pair_po}, 64'd1);
    chk_eq("resume_credit", {61'd0, credit_count}, 64'd0);
    tick();
    chk_idle("resume_after");

    // Three flits buffered (0x6, 0x7, 0x8) with one credit, then reset
    flit_in = 32'h7;
    flit_valid_in = 1'b1;
    tick();
    flit_in = 32'h8;
    credit_in = 1'b1;
    tick();
    flit_valid_in = 1'b0;
    credit_in = 1'b0;
    chk_eq("pre_rst_credit", {61'd0, credit_count}, 64'd1);
    chk_eq("pre_rst_err", {63'd0, credit_err}, 64'd0);
    do_reset();
    repeat (3) begin
      tick();
      chk_idle("post_rst");
    end
    chk_eq("post_rst_credit", {61'd0, credit_count}, 64'd4);
    chk_eq("post_rst_ready", {63'd0, flit_ready_out}, 64'd1);

    // Streaming 20 flits with a credit returned every cycle after the first send
    for (int i = 0; i < 20; i++) begin
      flit_in = 32'h100 + 32'(i);
      flit_valid_in = 1'b1;
      credit_in = (i >= 2);
      tick();
      if (i >= 1) begin
        chk_eq($sformatf("stream_chan%0d", i - 1), {32'd0, channel_out}, 64'h100 + 64'(i - 1));
        chk_eq("stream_po", {63'd0, diff_pair_po}, 64'd1);
        chk_eq("stream_credit", {61'd0, credit_count}, 64'd3);
      end
    end
    flit_valid_in = 1'b0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk_eq("stream_last", {32'd0, channel_out}, 64'h113);
    chk_eq("stream_last_credit", {61'd0, credit_count}, 64'd3);
    tick();
    chk_idle("stream_end");
    chk_eq("stream_err", {63'd0, credit_err}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
